serial_bus_bridge: RTL

- Memory-side bridge between the serialized 6502 core and the synchronous RAM model.
- Rebuilds the 16-bit CPU address from the phased byte stream and generates the RAM read/write strobes.
- Arbitrates RAM ownership across three phases: program load (loader drives RAM), run (CPU drives RAM), result dump (bridge reads a result window and streams it to the display stage).
- Replaces the ad-hoc address/strobe glue in the FPGA top with one checked, sequenced block.

---
 rtl/serial_bus_bridge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_bus_bridge.sv
// serial_bus_bridge: memory-side glue between the serialized 6502 core and
// the synchronous RAM. It rebuilds the CPU address from the phased byte
// stream, generates the RAM strobes, and sequences RAM ownership through the
// load, run and result-dump phases.
module serial_bus_bridge #(
  parameter logic [15:0] RESULT_ADDR = 16'hE200,
  parameter int          DUMP_LEN    = 8,
  parameter int          LH_LAST     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_active,
  input  logic [15:0] ld_addr,
  input  logic        ld_we,
  input  logic [7:0]  ld_data,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_lh,
  input  logic        cpu_rdy,
  input  logic        dump_req,
  input  logic [7:0]  ram_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic        ram_re,
  output logic [7:0]  ram_wdata,
  output logic [7:0]  cpu_di,
  output logic        dump_valid,
  output logic [7:0]  dump_data,
  output logic [7:0]  dump_idx,
  output logic        dump_done,
  output logic        phase_err,
  output logic [15:0] cpu_addr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DUMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Counter is one bit wider than the index so a 256-byte window still
  // has a distinct "all issued" value.
  localparam logic [8:0] LEN = 9'(DUMP_LEN);
  localparam logic [2:0] LHL = 3'(LH_LAST);

  logic [2:0] state;
  logic [7:0] abl, abh;
  logic [8:0] cnt;
  logic       dv_q;
  logic [7:0] idx_q;
  logic       err_q;
  logic [2:0] prev_lh;
  logic       prev_rdy;

  logic       wr, rd, issue, err_now, lh_bad, seq_bad;
  logic [2:0] nxt_lh;

  assign cpu_addr = {abh, abl};
  assign cpu_di   = ram_rdata;

  // Write wins over read: read is suppressed whenever a write strobes.
  assign wr    = cpu_we & cpu_rdy & (cpu_lh == 3'd5);
  assign rd    = ~wr & cpu_rdy & (cpu_lh == 3'd3);
  assign issue = (state == S_DUMP) && (cnt < LEN);

  // Phase legality: in range, and while the core is continuously enabled
  // the phase either holds or advances by one with wrap at LH_LAST.
  assign nxt_lh  = (prev_lh == LHL) ? 3'd0 : prev_lh + 3'd1;
  assign lh_bad  = cpu_lh > LHL;
  assign seq_bad = cpu_rdy & prev_rdy & (cpu_lh != prev_lh) & (cpu_lh != nxt_lh);
  assign err_now = ~reset & (state == S_RUN) & (lh_bad | seq_bad);

  // Error is visible in the offending cycle and sticks until reset.
  assign phase_err  = err_q | err_now;
  assign dump_valid = dv_q;
  assign dump_idx   = idx_q;
  assign dump_data  = dv_q ? ram_rdata : 8'h00;
  assign dump_done  = (state == S_DONE);

  // RAM port mux: owner depends on phase, strobes forced low in reset.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = '0;
    if (!reset) begin
      case (state)
        S_LOAD: begin
          ram_addr  = ld_addr;
          ram_we    = ld_we;
          ram_wdata = ld_data;
        end
        S_RUN: begin
          ram_addr  = cpu_addr;
          ram_we    = wr;
          ram_re    = rd;
          ram_wdata = cpu_do;
        end
        S_DUMP: begin
          if (issue) begin
            ram_addr = RESULT_ADDR + {7'd0, cnt};
            ram_re   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Phase sequencing, address capture and dump issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      abl   <= '0;
      abh   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (load_active) state <= S_LOAD;
        S_LOAD: if (!load_active) state <= S_RUN;
        S_RUN: begin
          if (cpu_lh == 3'd0) abl <= cpu_do;
          if (cpu_lh == 3'd2) abh <= cpu_do;
          if (dump_req) begin
            state <= S_DUMP;
            cnt   <= '0;
          end
        end
        S_DUMP: begin
          if (issue) cnt <= cnt + 9'd1;
          else       state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Dump beat tracking: a read issued this cycle returns data next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      dv_q  <= issue;
      idx_q <= cnt[7:0];
    end
  end

  // Phase checker history and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= 1'b0;
      prev_lh  <= '0;
      prev_rdy <= 1'b0;
    end else begin
      err_q    <= err_q | err_now;
      prev_lh  <= cpu_lh;
      prev_rdy <= (state == S_RUN) & cpu_rdy;
    end
  end

endmodule
